word_fifo: RTL and testbench

//  Downstream stage of bit_fifo: absorbs its OWIDTH-wide out/out_valid word stream and buffers it.

---
 rtl/word_fifo.sv | 99 +++++++++
 tb/tb_word_fifo.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_fifo.sv
// word_fifo: first-word-fall-through word buffer behind bit_fifo, with drop-on-full and a sticky overflow flag.
// Define WORD_FIFO_OVF_COUNT_EN to add a saturating 16-bit dropped-word counter (ovf_count).
module word_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in,
  input  logic                         in_valid,
  output logic [WIDTH-1:0]             out,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow
`ifdef WORD_FIFO_OVF_COUNT_EN
  ,
  output logic [15:0]                  ovf_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             overflow_reg;
  logic             pop;
  logic             push;
  logic             drop;

  // Every flag comes from the registered occupancy; pointers are only used for addressing.
  assign out_valid = (count_reg != '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign out       = mem[rd_ptr_reg];

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Storage carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (flush) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

`ifdef WORD_FIFO_OVF_COUNT_EN
  logic [15:0] ovf_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_reg <= '0;
    end else if (flush) begin
      ovf_count_reg <= '0;
    end else if (drop && (ovf_count_reg != 16'hFFFF)) begin
      ovf_count_reg <= ovf_count_reg + 16'd1;
    end
  end

  assign ovf_count = ovf_count_reg;
`endif

endmodule

// File: tb/tb_word_fifo.sv
// Bench for word_fifo (WIDTH=7, DEPTH=4): directed vector table, hand sequences, and random traffic
// checked against a queue-based reference; builds with or without WORD_FIFO_OVF_COUNT_EN.
module tb_word_fifo;

  localparam int WIDTH = 7;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] tb_in;
  logic             tb_in_valid;
  logic [WIDTH-1:0] tb_out;
  logic             tb_out_valid;
  logic             tb_out_ready;
  logic             tb_flush;
  logic [2:0]       tb_count;
  logic             tb_full;
  logic             tb_overflow;
`ifdef WORD_FIFO_OVF_COUNT_EN
  logic [15:0]      tb_ovf_count;
`endif

  word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (tb_in),
    .in_valid  (tb_in_valid),
    .out       (tb_out),
    .out_valid (tb_out_valid),
    .out_ready (tb_out_ready),
    .flush     (tb_flush),
    .count     (tb_count),
    .full      (tb_full),
    .overflow  (tb_overflow)
`ifdef WORD_FIFO_OVF_COUNT_EN
    ,
    .ovf_count (tb_ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: contents as a plain queue, plus sticky flag and drop tally.
  logic [WIDTH-1:0] mq[$];
  logic             m_ovf;
  int               m_oc;

  typedef struct {
    logic [6:0] d;
    logic       v;
    logic       r;
    logic       f;
    int         e_cnt;
    logic       e_val;
    logic [6:0] e_out;
    logic       e_full;
    logic       e_ovf;
    int         e_oc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ovf = 1'b0;
    m_oc  = 0;
  endtask

  task automatic model_edge(input logic [6:0] d, input logic v, input logic r, input logic f);
    bit do_pop;
    bit do_push;
    if (f) begin
      model_clear();
    end else begin
      do_pop  = (mq.size() > 0) && r;
      do_push = v && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (v && !do_push) begin
        m_ovf = 1'b1;
        if (m_oc < 65535) m_oc++;
      end
      if (do_push) mq.push_back(d);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".count"}, int'(tb_count), mq.size());
    chk({tag, ".out_valid"}, int'(tb_out_valid), int'(mq.size() != 0));
    chk({tag, ".full"}, int'(tb_full), int'(mq.size() == DEPTH));
    chk({tag, ".overflow"}, int'(tb_overflow), int'(m_ovf));
    if (mq.size() != 0) chk({tag, ".out"}, int'(tb_out), int'(mq[0]));
`ifdef WORD_FIFO_OVF_COUNT_EN
    chk({tag, ".ovf_count"}, int'(tb_ovf_count), m_oc);
`endif
  endtask

  // One clock: drive on negedge, update reference at posedge, sample 1ns later.
  task automatic step(input string tag, input logic [6:0] d, input logic v, input logic r,
                      input logic f);
    @(negedge clk);
    tb_in        = d;
    tb_in_valid  = v;
    tb_out_ready = r;
    tb_flush     = f;
    @(posedge clk);
    model_edge(d, v, r, f);
    #1;
    $display("%s: in=%h iv=%b rdy=%b fl=%b -> cnt=%0d ov=%b out=%h full=%b ovf=%b",
             tag, d, v, r, f, tb_count, tb_out_valid, tb_out, tb_full, tb_overflow);
    compare_model(tag);
  endtask

  task automatic add(input logic [6:0] d, input logic v, input logic r, input logic f,
                     input int c, input logic val, input logic [6:0] o, input logic fu,
                     input logic ov, input int oc);
    vec_t t;
    t.d = d; t.v = v; t.r = r; t.f = f;
    t.e_cnt = c; t.e_val = val; t.e_out = o; t.e_full = fu; t.e_ovf = ov; t.e_oc = oc;
    vecs.push_back(t);
  endtask

  task automatic add_fill(input int oc);
    add(7'h11, 1, 0, 0, 1, 1, 7'h11, 0, 0, oc);
    add(7'h22, 1, 0, 0, 2, 1, 7'h11, 0, 0, oc);
    add(7'h33, 1, 0, 0, 3, 1, 7'h11, 0, 0, oc);
    add(7'h44, 1, 0, 0, 4, 1, 7'h11, 1, 0, oc);
  endtask

  initial begin
    rst          = 1'b1;
    tb_in        = '0;
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b0;
    tb_flush     = 1'b0;
    model_clear();

    // Fill and drain, then out_ready on empty must not underflow.
    add_fill(0);
    add(7'h00, 0, 1, 0, 3, 1, 7'h22, 0, 0, 0);
    add(7'h00, 0, 1, 0, 2, 1, 7'h33, 0, 0, 0);
    add(7'h00, 0, 1, 0, 1, 1, 7'h44, 0, 0, 0);
    add(7'h00, 0, 1, 0, 0, 0, 7'h00, 0, 0, 0);
    add(7'h00, 0, 1, 0, 0, 0, 7'h00, 0, 0, 0);
    // Overflow: two drops, contents intact, then flush with a word arriving.
    add_fill(0);
    add(7'h55, 1, 0, 0, 4, 1, 7'h11, 1, 1, 1);
    add(7'h56, 1, 0, 0, 4, 1, 7'h11, 1, 1, 2);
    add(7'h00, 0, 1, 0, 3, 1, 7'h22, 0, 1, 2);
    add(7'h00, 0, 1, 0, 2, 1, 7'h33, 0, 1, 2);
    add(7'h55, 1, 0, 1, 0, 0, 7'h00, 0, 0, 0);
    // Full with simultaneous pop accepts the new word.
    add_fill(0);
    add(7'h66, 1, 1, 0, 4, 1, 7'h22, 1, 0, 0);
    add(7'h00, 0, 1, 0, 3, 1, 7'h33, 0, 0, 0);
    add(7'h00, 0, 1, 0, 2, 1, 7'h44, 0, 0, 0);
    add(7'h00, 0, 1, 0, 1, 1, 7'h66, 0, 0, 0);
    add(7'h00, 0, 1, 0, 0, 0, 7'h00, 0, 0, 0);
    // Flush beats a would-be drop on the same edge.
    add_fill(0);
    add(7'h77, 1, 0, 1, 0, 0, 7'h00, 0, 0, 0);

    #3;
    chk("reset.count", int'(tb_count), 0);
    chk("reset.out_valid", int'(tb_out_valid), 0);
    chk("reset.full", int'(tb_full), 0);
    chk("reset.overflow", int'(tb_overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step("idle", 7'h00, 1'b0, 1'b1, 1'b0);
      chk("idle.out_valid", int'(tb_out_valid), 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].d, vecs[i].v, vecs[i].r, vecs[i].f);
      chk($sformatf("vec%0d.count", i), int'(tb_count), vecs[i].e_cnt);
      chk($sformatf("vec%0d.out_valid", i), int'(tb_out_valid), int'(vecs[i].e_val));
      chk($sformatf("vec%0d.full", i), int'(tb_full), int'(vecs[i].e_full));
      chk($sformatf("vec%0d.overflow", i), int'(tb_overflow), int'(vecs[i].e_ovf));
      if (vecs[i].e_val) chk($sformatf("vec%0d.out", i), int'(tb_out), int'(vecs[i].e_out));
`ifdef WORD_FIFO_OVF_COUNT_EN
      chk($sformatf("vec%0d.ovf_count", i), int'(tb_ovf_count), vecs[i].e_oc);
`endif
    end

    // Streaming through wrap: occupancy stays at one word.
    for (int i = 0; i < 20; i++) begin
      step($sformatf("stream%0d", i), 7'(i), 1'b1, 1'b1, 1'b0);
      chk("stream.count", int'(tb_count), 1);
      chk("stream.out", int'(tb_out), i);
      chk("stream.overflow", int'(tb_overflow), 0);
    end
    step("stream_drain", 7'h00, 1'b0, 1'b1, 1'b0);

    // Async reset between edges with count=3 and overflow set.
    for (int i = 1; i <= 4; i++) step("pre_rst_fill", 7'(i), 1'b1, 1'b0, 1'b0);
    step("pre_rst_drop", 7'h05, 1'b1, 1'b0, 1'b0);
    step("pre_rst_pop", 7'h00, 1'b0, 1'b1, 1'b0);
    chk("pre_rst.count", int'(tb_count), 3);
    chk("pre_rst.overflow", int'(tb_overflow), 1);
    @(negedge clk);
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    $display("async_rst: cnt=%0d ov=%b ovf=%b", tb_count, tb_out_valid, tb_overflow);
    chk("async_rst.count", int'(tb_count), 0);
    chk("async_rst.out_valid", int'(tb_out_valid), 0);
    chk("async_rst.overflow", int'(tb_overflow), 0);
    chk("async_rst.full", int'(tb_full), 0);
`ifdef WORD_FIFO_OVF_COUNT_EN
    chk("async_rst.ovf_count", int'(tb_ovf_count), 0);
`endif
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 7'h7F, 1'b1, 1'b0, 1'b0);
    chk("post_rst.out", int'(tb_out), 'h7F);
    chk("post_rst.count", int'(tb_count), 1);

    // Random traffic, biased toward filling so drops and full-with-pop occur.
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i), 7'($urandom_range(0, 127)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
